// File: rtl/wdata_chan_slv.sv
// ============================================================================
// wdata_chan_slv
// ----------------------------------------------------------------------------
// Slave-side write data channel receiver. It accepts a write command
// (ID and byte address), takes a fixed 4-beat, 32-bit write burst over the
// wvalid/wready/wlast handshake, and packs the beats into one 128-bit line.
// It then holds a single line write toward memory until mem_ready, and
// reports completion (ID and wlast protocol error) with a one-cycle wfin
// pulse.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   start_rq/_id/_addr         write command from the address channel,
//                              held until start_ack
//   start_ack                  command accepted this cycle (combinational)
//   wvalid/wready/wdata/wlast  bus write data channel
//   mem_we/mem_ready           line write strobe and memory accept
//   mem_addr/mem_wdata         line-aligned address and assembled line
//   wfin/wfin_id/wfin_err      completion pulse, burst ID, wlast error
// ============================================================================
module wdata_chan_slv (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_rq,
    input  logic [3:0]   start_id,
    input  logic [31:0]  start_addr,
    output logic         start_ack,
    input  logic         wvalid,
    output logic         wready,
    input  logic [31:0]  wdata,
    input  logic         wlast,
    output logic         mem_we,
    input  logic         mem_ready,
    output logic [31:0]  mem_addr,
    output logic [127:0] mem_wdata,
    output logic         wfin,
    output logic [3:0]   wfin_id,
    output logic         wfin_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DEFO  = 2'd3   // sticky trap: every strobe stays inactive
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     id_q,    id_d;
    logic [27:0]    line_q,  line_d;   // line address bits [31:4]
    logic [1:0]     cnt_q,   cnt_d;    // beat index within the burst
    logic           err_q,   err_d;
    logic [127:0]   buf_q,   buf_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        id_d      = id_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        buf_d     = buf_q;
        start_ack = 1'b0;
        wready    = 1'b0;
        mem_we    = 1'b0;
        wfin      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                start_ack = start_rq;
                if (start_rq) begin
                    state_d = ST_RECV;
                end
            end

            ST_RECV: begin
                // wready depends on state only, never on wvalid.
                wready = 1'b1;
                if (wvalid) begin
                    buf_d[{cnt_q, 5'b0} +: 32] = wdata;
                    cnt_d = cnt_q + 2'd1;
                    // wlast must be set on the last beat and only there.
                    // An early wlast is flagged but does not end the burst.
                    if (wlast != (cnt_q == 2'd3)) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == 2'd3) begin
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                mem_we = 1'b1;
                wfin   = mem_ready;
                // A waiting command is taken only in the completion cycle,
                // which gives back-to-back bursts without a dead cycle.
                if (mem_ready) begin
                    start_ack = start_rq;
                    state_d   = start_rq ? ST_RECV : ST_IDLE;
                end
            end

            default: begin
                state_d = ST_DEFO;
            end
        endcase

        if (start_ack) begin
            id_d   = start_id;
            line_d = start_addr[31:4];
            cnt_d  = 2'd0;
            err_d  = 1'b0;
        end
    end

    // NOTE: the line buffer is reset along with the control state, so an
    // aborted burst leaves no stale data visible on mem_wdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            buf_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            state_q <= state_d;
            id_q    <= id_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_addr  = {line_q, 4'b0000};
    assign mem_wdata = buf_q;
    assign wfin_id   = id_q;
    assign wfin_err  = err_q;

endmodule

// File: tb/tb_wdata_chan_slv.sv
// ============================================================================
// tb_wdata_chan_slv
// ----------------------------------------------------------------------------
// Self-checking bench for wdata_chan_slv. Each burst is described as a
// transaction: ID, address, the 128-bit line and the per-beat wlast pattern.
// From that description the expected line, line address and error flag come
// from plain arithmetic. Inputs change 1 ns after the rising edge. Outputs
// are sampled on the falling edge.
// ============================================================================
module tb_wdata_chan_slv;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_rq;
    logic [3:0]   start_id;
    logic [31:0]  start_addr;
    logic         start_ack;
    logic         wvalid;
    logic         wready;
    logic [31:0]  wdata;
    logic         wlast;
    logic         mem_we;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         wfin;
    logic [3:0]   wfin_id;
    logic         wfin_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Command that will be held during the current burst (back-to-back).
    logic [3:0]  nxt_id;
    logic [31:0] nxt_addr;

    always #5 clk = ~clk;

    wdata_chan_slv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_rq   (start_rq),
        .start_id   (start_id),
        .start_addr (start_addr),
        .start_ack  (start_ack),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wlast      (wlast),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .wfin       (wfin),
        .wfin_id    (wfin_id),
        .wfin_err   (wfin_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete burst. On entry the bench sits 1 ns after a rising edge.
    // With acked=1 the command was already accepted at the previous edge.
    // With chain=1, nxt_id/nxt_addr are requested from the first beat cycle
    // on. gap_mode: 0 gapless, 1 alternating, 2 random. stall_n >= 0 gives
    // that many mem_ready=0 cycles; a negative value gives random stalls.
    task automatic burst(input logic [3:0] id, input logic [31:0] addr,
                         input logic [127:0] line, input logic [3:0] last,
                         input int gap_mode, input int stall_n,
                         input bit acked, input bit chain, output int lat);
        bit exp_err;
        int idx, cyc, budget, we_cyc;
        bit done;
        exp_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (last[i] != (i == 3)) exp_err = 1'b1;
        end
        lat = -1;

        if (!acked) begin
            start_rq   = 1'b1;
            start_id   = id;
            start_addr = addr;
            @(negedge clk);
            check("cmd_ack", start_ack, 1'b1);
            next_cycle();
            start_rq   = 1'b0;
            start_id   = $urandom;
            start_addr = $urandom;
        end
        cyc = 1;

        if (chain) begin
            start_rq   = 1'b1;
            start_id   = nxt_id;
            start_addr = nxt_addr;
        end

        // Data beats.
        idx = 0;
        budget = 0;
        while (idx < 4 && budget < 100) begin
            case (gap_mode)
                0:       wvalid = 1'b1;
                1:       wvalid = (budget % 2) == 0;
                default: wvalid = $urandom_range(99) >= 40;
            endcase
            wdata = wvalid ? line[32*idx +: 32] : $urandom;
            wlast = wvalid ? last[idx] : 1'($urandom_range(1));
            @(negedge clk);
            check("wready_recv", wready, 1'b1);
            check("mem_we_recv", mem_we, 1'b0);
            if (chain) check("ack_in_recv", start_ack, 1'b0);
            if (wvalid && wready) idx++;
            next_cycle();
            cyc++;
            budget++;
        end
        if (idx < 4) check("beat_budget", idx, 4);
        wvalid = 1'b0;
        wlast  = 1'b0;

        // Line write.
        done = 1'b0;
        budget = 0;
        we_cyc = 0;
        while (!done && budget < 100) begin
            mem_ready = (stall_n >= 0) ? (budget >= stall_n) : ($urandom_range(99) >= 30);
            wvalid    = 1'($urandom_range(1));   // must be ignored while wready=0
            wdata     = $urandom;
            @(negedge clk);
            check("mem_we_write", mem_we, 1'b1);
            check("wready_write", wready, 1'b0);
            check("wfin_pulse", wfin, mem_ready);
            check("ack_in_write", start_ack, chain && mem_ready);
            we_cyc++;
            if (mem_ready) begin
                check("line_data", mem_wdata, line);
                check("line_addr", mem_addr, {addr[31:4], 4'b0000});
                check("wfin_id", wfin_id, id);
                check("wfin_err", wfin_err, exp_err);
                lat  = cyc;
                done = 1'b1;
            end
            next_cycle();
            cyc++;
            budget++;
        end
        if (!done) check("write_budget", done, 1'b1);
        if (stall_n >= 0) check("we_cycles", we_cyc, stall_n + 1);
        mem_ready = 1'b0;
        wvalid    = 1'b0;
        if (chain) start_rq = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit pend, chain_now;
        logic [3:0]   id;
        logic [31:0]  addr;
        logic [127:0] line;
        logic [3:0]   last;

        rst_n = 1'b0; start_rq = 1'b0; start_id = '0; start_addr = '0;
        wvalid = 1'b0; wdata = '0; wlast = 1'b0; mem_ready = 1'b0;
        nxt_id = '0; nxt_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_ack", start_ack, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_wfin", wfin, 1'b0);
        check("rst_wfin_id", wfin_id, 4'h0);
        check("rst_wfin_err", wfin_err, 1'b0);
        next_cycle();

        // wvalid while idle must not be taken.
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wlast = 1'b1;
        @(negedge clk);
        check("idle_wready", wready, 1'b0);
        next_cycle();
        wvalid = 1'b0; wlast = 1'b0;
        check("idle_buf", mem_wdata, 128'h0);

        // Basic burst, including latency and the return to idle.
        burst(4'h5, 32'h0000_1234, 128'h44444444_33333333_22222222_11111111,
              4'b1000, 0, 0, 1'b0, 1'b0, lat);
        check("basic_latency", lat, 5);
        @(negedge clk);
        check("idle_after_wready", wready, 1'b0);
        check("idle_after_mem_we", mem_we, 1'b0);
        next_cycle();

        // Alternating wvalid and a 3-cycle memory stall.
        burst(4'h3, 32'h8000_0040, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3,
              4'b1000, 1, 3, 1'b0, 1'b0, lat);

        // wlast errors: early wlast, then clean, then no wlast at all.
        burst(4'h7, 32'h0000_0100, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A,
              4'b0010, 0, 0, 1'b0, 1'b0, lat);
        burst(4'h8, 32'h0000_0110, 128'h1D1D1D1D_1C1C1C1C_1B1B1B1B_1A1A1A1A,
              4'b1000, 0, 0, 1'b0, 1'b0, lat);
        burst(4'h9, 32'h0000_0120, 128'h2D2D2D2D_2C2C2C2C_2B2B2B2B_2A2A2A2A,
              4'b0000, 0, 0, 1'b0, 1'b0, lat);

        // Back-to-back: second command held from the first beat cycle.
        nxt_id = 4'hA; nxt_addr = 32'h0000_2008;
        burst(4'h1, 32'h0000_2000, 128'h13131313_12121212_11111111_10101010,
              4'b1000, 0, 0, 1'b0, 1'b1, lat);
        burst(4'hA, 32'h0000_2008, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0,
              4'b1000, 0, 0, 1'b1, 1'b0, lat);
        check("b2b_latency", lat, 5);

        // Reset after two beats.
        start_rq = 1'b1; start_id = 4'hC; start_addr = 32'h0000_3000;
        @(negedge clk);
        check("rst_test_ack", start_ack, 1'b1);
        next_cycle();
        start_rq = 1'b0;
        wvalid = 1'b1; wdata = 32'hCAFE_0000; wlast = 1'b0;
        next_cycle();
        wdata = 32'hCAFE_0001;
        next_cycle();
        wvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_wready", wready, 1'b0);
        check("midrst_mem_we", mem_we, 1'b0);
        check("midrst_wfin", wfin, 1'b0);
        check("midrst_buf", mem_wdata, 128'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        burst(4'hD, 32'h0000_4444, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0,
              4'b1000, 0, 0, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, 5);

        // Randomized bursts with random gaps, stalls, wlast and chaining.
        pend = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (pend) begin
                id = nxt_id; addr = nxt_addr;
            end else begin
                id = 4'($urandom); addr = $urandom;
            end
            line = {$urandom, $urandom, $urandom, $urandom};
            last = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1000;
            chain_now = (k < 39) && ($urandom_range(1) == 1);
            if (chain_now) begin
                nxt_id = 4'($urandom); nxt_addr = $urandom;
            end
            burst(id, addr, line, last, 2, -1, pend, chain_now, lat);
            pend = chain_now;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
